shift_arbiter: RTL
==================

Name: shift_arbiter

Overview:
- Shares one combinational shift datapath (module `shifter`) between two requesters: port 0 is the execute-stage ALU shift path, port 1 is the load/store byte-alignment path.
- Arbitrates with round-robin or fixed priority and drives the granted operands into the shifter.
- Registers the result into a one-entry response buffer with valid/ready handshake and requester ID.
- Latency 1 cycle; full throughput of 1 result per cycle when the response is consumed every cycle.

Parameters:
- PRIO_FIXED, 0, 0 = round-robin between ports; 1 = port 0 always wins when both are valid.
- RR_INIT, 0, reset value of the round-robin pointer (port favoured first after reset).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- req0_valid  input  1  port 0 request valid.
- req0_ready  output  1  port 0 request accepted this cycle.
- req0_a  input  32  port 0 operand, signed.
- req0_shamt  input  5  port 0 shift amount.
- req0_type  input  2  port 0 shift type code.
- req1_valid  input  1  port 1 request valid.
- req1_ready  output  1  port 1 request accepted this cycle.
- req1_a  input  32  port 1 operand, signed.
- req1_shamt  input  5  port 1 shift amount.
- req1_type  input  2  port 1 shift type code.
- rsp_valid  output  1  response buffer holds a result.
- rsp_ready  input  1  consumer takes the response this cycle.
- rsp_data  output  32  shift result.
- rsp_id  output  1  ID of the requester that produced rsp_data.

Behaviour:
- Type codes:
  - 00 = SRL (zero fill).
  - 01 = SLL.
  - 10 = SRA (sign fill from bit 31).
  - 11 = pass operand unchanged.
  - shamt is 0..31; there is no wrap and no masking beyond 5 bits.
- Grant (combinational):
  - Only one port valid: that port is granted.
  - Both valid, PRIO_FIXED=0: the port named by ptr is granted.
  - Both valid, PRIO_FIXED=1: port 0 is granted.
  - Neither valid: no grant.
- Buffer space: space = !rsp_valid || rsp_ready.
- Accept: accept = (grant exists) && space. reqN_ready = accept && grant==N.
  - ready may depend on valid; requesters must not make valid depend on ready.
  - At most one ready is high per cycle.
- Operand mux: granted port's a/shamt/type drive the shifter. With no grant, port 0 operands drive it; the result is ignored.
- On the clock edge with accept:
  - rsp_data <= shifter result.
  - rsp_id <= granted port.
  - rsp_valid <= 1.
- Response held: if rsp_valid && !rsp_ready, rsp_data and rsp_id stay stable and no request is accepted (backpressure propagates to both ports).
- Response consumed, no new accept: if rsp_valid && rsp_ready && !accept, rsp_valid <= 0.
- Simultaneous consume and accept: the buffer is refilled in the same edge, so rsp_valid stays 1 and the data is replaced. There is no bubble.
- Round-robin pointer:
  - On every accept, ptr <= ~granted port, including single-requester accepts.
  - ptr is unchanged when there is no accept.
  - With both ports continuously valid and rsp_ready=1, grants alternate 0,1,0,1...
  - Worst-case wait for a valid requester is 1 accepted transaction.
  - With PRIO_FIXED=1, ptr still updates but is unused.
- Reset (rst=0 sampled at a clock edge):
  - rsp_valid=0, rsp_data=0, rsp_id=0, ptr=RR_INIT.
  - Any pending response is discarded.
  - req0_ready and req1_ready are forced to 0 while rst=0, regardless of valid.
- Requests are never dropped: a request held valid is eventually accepted once rsp_ready is asserted.

Decomposition:
- Shared package/header (`shift_pkg`):
  - Constants SHIFT_SRL=2'b00, SHIFT_SLL=2'b01, SHIFT_SRA=2'b10, SHIFT_PASS=2'b11.
  - Requester IDs REQ_ALU=1'b0, REQ_ALIGN=1'b1.
- One sub-module: the existing `shifter` (a, shamt, type -> r), instantiated once. Arbiter, mux and response register live in shift_arbiter.
- No other sub-modules.

Test Plan:
- Reset and single request: hold rst=0 for 2 cycles with req0_valid=1, expect req0_ready=0 and rsp_valid=0. Release rst, send req0 a=0x80000000, shamt=4, type=10 -> next cycle rsp_valid=1, rsp_data=0xF8000000, rsp_id=0.
- All shift types on port 1, one per cycle with rsp_ready=1, a=0x80000001:
  - shamt=1, type=00 -> 0x40000000.
  - shamt=1, type=01 -> 0x00000002.
  - shamt=31, type=10 -> 0xFFFFFFFF.
  - type=11 -> 0x80000001.
  - Each result has rsp_id=1, back-to-back with no bubbles.
- Contention, round-robin: both ports continuously valid (req0 a=1, shamt=1, type=01; req1 a=4, shamt=2, type=00), RR_INIT=0, rsp_ready=1 -> rsp_id sequence 0,1,0,1 and rsp_data sequence 2,1,2,1.
- Backpressure: fill the buffer, then hold rsp_ready=0 for 3 cycles with both ports valid -> both readys stay 0, rsp_data/rsp_id stable. Raise rsp_ready -> the old response is consumed and the next request is accepted in the same edge, with no bubble.
- Fixed priority (PRIO_FIXED=1): both ports valid for 4 cycles -> rsp_id=0 every cycle and req1_ready stays 0. Drop req0_valid -> req1 is accepted next cycle.
- Reset mid-operation: rsp_valid=1 with rsp_ready=0, assert rst=0 for 1 cycle -> rsp_valid=0, rsp_data=0. The next contended accept follows RR_INIT.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared constants and request bundle for the shift arbiter slice.
package shift_pkg;

   localparam logic [1:0] SHIFT_SRL  = 2'b00;
   localparam logic [1:0] SHIFT_SLL  = 2'b01;
   localparam logic [1:0] SHIFT_SRA  = 2'b10;
   localparam logic [1:0] SHIFT_PASS = 2'b11;

   localparam logic REQ_ALU   = 1'b0;
   localparam logic REQ_ALIGN = 1'b1;

   typedef struct packed {
      logic [31:0] a;
      logic [4:0]  shamt;
      logic [1:0]  op;
   } shift_req_t;

endpackage

// File: rtl/shifter.sv
// Combinational barrel shifter: SRL, SLL, SRA or pass-through.
module shifter
   import shift_pkg::*;
(
   input  logic [31:0] a,
   input  logic [4:0]  shamt,
   input  logic [1:0]  op,
   output logic [31:0] r
);

   always_comb begin
      r = a;
      unique case (op)
         SHIFT_SRL:  r = a >> shamt;
         SHIFT_SLL:  r = a << shamt;
         SHIFT_SRA:  r = $signed(a) >>> shamt;
         SHIFT_PASS: r = a;
      endcase
   end

endmodule

// File: rtl/shift_arbiter.sv
// Two-port arbiter sharing one shifter, with a one-entry
// response buffer carrying the requester ID.
module shift_arbiter
   import shift_pkg::*;
#(
   parameter bit PRIO_FIXED = 1'b0,
   parameter bit RR_INIT    = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [4:0]  req0_shamt,
   input  logic [1:0]  req0_type,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [4:0]  req1_shamt,
   input  logic [1:0]  req1_type,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_id
);

   logic       ptr;
   logic       gnt_v;
   logic       gnt_id;
   logic       space;
   logic       accept;
   shift_req_t r0;
   shift_req_t r1;
   shift_req_t sel;
   logic [31:0] result;

   assign r0 = '{a: req0_a, shamt: req0_shamt, op: req0_type};
   assign r1 = '{a: req1_a, shamt: req1_shamt, op: req1_type};

   always_comb begin
      gnt_v  = req0_valid | req1_valid;
      gnt_id = REQ_ALU;
      unique case (1'b1)
         (req0_valid && req1_valid):
            gnt_id = PRIO_FIXED ? REQ_ALU : ptr;
         (!req0_valid && req1_valid):
            gnt_id = REQ_ALIGN;
         default:
            gnt_id = REQ_ALU;
      endcase
   end

   // Readys are gated by reset so nothing is taken while held.
   assign space      = !rsp_valid || rsp_ready;
   assign accept     = gnt_v && space && rst;
   assign req0_ready = accept && (gnt_id == REQ_ALU);
   assign req1_ready = accept && (gnt_id == REQ_ALIGN);

   assign sel = (gnt_id == REQ_ALIGN) ? r1 : r0;

   shifter u_shifter (
      .a     (sel.a),
      .shamt (sel.shamt),
      .op    (sel.op),
      .r     (result)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_id    <= 1'b0;
         ptr       <= RR_INIT;
      end else if (accept) begin
         rsp_valid <= 1'b1;
         rsp_data  <= result;
         rsp_id    <= gnt_id;
         ptr       <= ~gnt_id;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule
